mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 CLK  in  1  rising-edge clock.
REQ-002 RST  in  1  synchronous, active-high reset.
REQ-003 Valid_in  in  1  instruction present from EX latch.
REQ-004 Wr_id_in  in  5  destination register id; 0 = no write.
REQ-005 Fmask_in  in  8  flag write mask.
REQ-006 Result_in  in  16  ALU result / store data.
REQ-007 Flags_in  in  8  flags from EX.
REQ-008 Addr_in  in  16  memory address.
REQ-009 Mem_op_in  in  2  00 none, 01 read, 10 write, 11 treated as none.
REQ-010 Mem_size_in  in  1  0 byte, 1 word (little-endian).
REQ-011 stall_in  in  1  downstream hold.
REQ-012 mem_req  out  1  bus request, registered.
REQ-013 mem_we  out  1  bus write enable, registered.
REQ-014 mem_addr  out  16  bus address, registered.
REQ-015 mem_wdata  out  8  bus write byte, registered.
REQ-016 mem_rdata  in  8  bus read byte.
REQ-017 mem_ack  in  1  bus completion, one cycle per byte.
REQ-018 Wr_id_out, Fmask_out, Result_out, Flags_out  out  5/8/16/8  to MEM latch.
REQ-019 stall_out  out  1  freeze upstream latches.

Function
REQ-020 States IDLE, LO, HI, DONE; state and bus outputs change only on CLK.
REQ-021 IDLE, no valid memory op: outputs combinationally equal inputs, stall_out=0.
REQ-022 IDLE, Valid_in and op 01/10: stall_out=1, bubble out (Wr_id_out=0, Fmask_out=0); next edge -> LO, mem_req=1, mem_addr=Addr_in, mem_we=(op==10), mem_wdata=Result_in[7:0].
REQ-023 LO: mem_req held until mem_ack; on ack capture mem_rdata into data_lo; word -> HI with mem_addr=Addr_in+1 (mod 2^16, FFFF wraps to 0000), mem_wdata=Result_in[15:8]; byte -> DONE with mem_req=0.
REQ-024 HI: mem_req held until mem_ack; on ack capture data_hi, -> DONE, mem_req=0.
REQ-025 LO and HI: stall_out=1, bubble out.
REQ-026 DONE: stall_out=0; Wr_id_out=Wr_id_in, Fmask_out=Fmask_in, Flags_out=Flags_in; Result_out = read ? {word?data_hi:8'h00, data_lo} : Result_in; -> IDLE unless stall_in=1, then stay DONE.
REQ-027 mem_ack while mem_req=0 ignored; ack in the cycle req is first asserted is accepted.
REQ-028 Inputs stable while stall_out=1 (guaranteed upstream); no re-sampling needed.
REQ-029 Access latency: byte = 2 + wait cycles, word = 3 + waits per byte.

Reset
REQ-030 RST: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_lo=data_hi=0.
REQ-031 RST mid-access: mem_req low after the reset edge; later acks ignored; no partial result emitted.

Structure
REQ-032 Shared package holds state encodings, Mem_op codes, size codes.
REQ-033 One sub-module natural: mem_stage_seq (FSM plus bus registers); output mux in top.

Verification
REQ-034 ALU op, Wr_id_in=5, Result_in=1234 -> same-cycle Result_out=1234, stall_out=0.
REQ-035 Byte read Addr_in=8000, ack after 2 waits, rdata=A5 -> stall 4 cycles, Result_out=00A5, Wr_id_out passed in DONE.
REQ-036 Word read Addr_in=FFFF, rdata 34 then 12 -> addresses FFFF then 0000, Result_out=1234.
REQ-037 Word write Result_in=BEEF at C000 -> bus writes EF@C000, BE@C001, mem_we=1 both.
REQ-038 RST asserted in HI -> next cycle IDLE, mem_req=0, stall_out=0; stray ack ignored.
REQ-039 DONE with stall_in=1 for 3 cycles -> outputs held, stays DONE, no new mem_req.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state, memory-op and access-size encodings for the MEM stage.
package mem_stage_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;
endpackage

// File: rtl/mem_stage_seq.sv
// mem_stage_seq: access FSM owning the byte-serial bus registers and captured read bytes.
module mem_stage_seq
  import mem_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_i,
  input  logic        is_wr_i,
  input  logic        word_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        stall_i,
  input  logic [7:0]  rdata_i,
  input  logic        ack_i,
  output state_e      state_o,
  output logic        req_o,
  output logic        we_o,
  output logic [15:0] addr_o,
  output logic [7:0]  wdata_o,
  output logic [7:0]  data_lo_o,
  output logic [7:0]  data_hi_o
);
  state_e      state_q;
  logic        req_q, we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, lo_q, hi_q;
  logic        acked;
  assign acked = ack_i && req_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q <= S_LO;
          req_q   <= 1'b1;
          we_q    <= is_wr_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i[7:0];
        end
        S_LO: if (acked) begin
          lo_q <= rdata_i;
          if (word_i) begin
            state_q <= S_HI;
            addr_q  <= addr_i + 16'd1;
            wdata_q <= wdata_i[15:8];
          end else begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        S_HI: if (acked) begin
          hi_q    <= rdata_i;
          state_q <= S_DONE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
        end
        default: if (!stall_i) state_q <= S_IDLE;
      endcase
    end
  end
  assign state_o   = state_q;
  assign req_o     = req_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign data_lo_o = lo_q;
  assign data_hi_o = hi_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; sequences byte-wide bus accesses and muxes results to the MEM latch.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid_in,
  input  logic [4:0]  Wr_id_in,
  input  logic [7:0]  Fmask_in,
  input  logic [15:0] Result_in,
  input  logic [7:0]  Flags_in,
  input  logic [15:0] Addr_in,
  input  logic [1:0]  Mem_op_in,
  input  logic        Mem_size_in,
  input  logic        stall_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  Wr_id_out,
  output logic [7:0]  Fmask_out,
  output logic [15:0] Result_out,
  output logic [7:0]  Flags_out,
  output logic        stall_out
);
  state_e     state;
  logic [7:0] data_lo, data_hi;
  logic       is_rd, is_wr, busy;
  assign is_rd = Mem_op_in == OP_RD;
  assign is_wr = Mem_op_in == OP_WR;
  mem_stage_seq u_seq (
    .CLK       (CLK),
    .RST       (RST),
    .start_i   (Valid_in && (is_rd || is_wr)),
    .is_wr_i   (is_wr),
    .word_i    (Mem_size_in == SZ_WORD),
    .addr_i    (Addr_in),
    .wdata_i   (Result_in),
    .stall_i   (stall_in),
    .rdata_i   (mem_rdata),
    .ack_i     (mem_ack),
    .state_o   (state),
    .req_o     (mem_req),
    .we_o      (mem_we),
    .addr_o    (mem_addr),
    .wdata_o   (mem_wdata),
    .data_lo_o (data_lo),
    .data_hi_o (data_hi)
  );
  // A memory op in IDLE stalls immediately so the launching cycle also emits a bubble.
  assign busy = (state == S_LO) || (state == S_HI) || (state == S_IDLE && Valid_in && (is_rd || is_wr));
  always_comb begin
    stall_out  = busy;
    Wr_id_out  = busy ? 5'd0 : Wr_id_in;
    Fmask_out  = busy ? 8'd0 : Fmask_in;
    Flags_out  = Flags_in;
    Result_out = (state == S_DONE && is_rd) ? {(Mem_size_in == SZ_WORD) ? data_hi : 8'h00, data_lo} : Result_in;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage with a scripted byte-serial bus responder.
module tb_mem_stage;
  logic        CLK = 1'b0;
  logic        RST, Valid_in, Mem_size_in, stall_in, mem_ack;
  logic [4:0]  Wr_id_in;
  logic [7:0]  Fmask_in, Flags_in, mem_rdata;
  logic [15:0] Result_in, Addr_in;
  logic [1:0]  Mem_op_in;
  logic        mem_req, mem_we, stall_out;
  logic [15:0] mem_addr, Result_out;
  logic [7:0]  mem_wdata, Fmask_out, Flags_out;
  logic [4:0]  Wr_id_out;

  mem_stage dut (
    .CLK(CLK), .RST(RST), .Valid_in(Valid_in), .Wr_id_in(Wr_id_in), .Fmask_in(Fmask_in),
    .Result_in(Result_in), .Flags_in(Flags_in), .Addr_in(Addr_in), .Mem_op_in(Mem_op_in),
    .Mem_size_in(Mem_size_in), .stall_in(stall_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Wr_id_out(Wr_id_out), .Fmask_out(Fmask_out), .Result_out(Result_out),
    .Flags_out(Flags_out), .stall_out(stall_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [15:0] res; logic [4:0] id;} exp_t;
  typedef struct {logic we; logic [15:0] addr; logic [7:0] wd;} bus_t;
  exp_t sb_q[$];
  bus_t bus_q[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic sz, input logic [15:0] addr,
                       input logic [15:0] res, input logic [4:0] id);
    Valid_in = 1'b1; Mem_op_in = op; Mem_size_in = sz; Addr_in = addr;
    Result_in = res; Wr_id_in = id; Fmask_in = 8'hF0; Flags_in = 8'h5A;
  endtask

  task automatic push_bus(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    bus_t b;
    b.we = we; b.addr = addr; b.wd = wd;
    bus_q.push_back(b);
  endtask

  task automatic push_exp(input logic [15:0] res, input logic [4:0] id);
    exp_t e;
    e.res = res; e.id = id;
    sb_q.push_back(e);
  endtask

  // Called just after a posedge with the instruction driven; returns at the negedge of the
  // first non-stalled cycle (DONE for memory ops, the same cycle for ALU ops).
  task automatic run_op(input string tag, input int waits, input logic [7:0] rd0,
                        input logic [7:0] rd1, input int exp_stalls);
    int stalls = 0;
    int w = 0;
    int nb = 0;
    int cyc = 0;
    exp_t e;
    bus_t b;
    @(negedge CLK);
    while (stall_out && cyc < 60) begin
      stalls++; cyc++;
      chk({tag, " bubble"}, {Wr_id_out, Fmask_out}, 32'd0);
      if (mem_req) begin
        if (w == waits) begin
          mem_ack = 1'b1; mem_rdata = (nb == 0) ? rd0 : rd1; nb++; w = 0;
          if (bus_q.size() == 0) chk({tag, " unexpected bus"}, 32'd1, 32'd0);
          else begin
            b = bus_q.pop_front();
            chk({tag, " bus"}, {mem_we, mem_addr, mem_wdata}, {b.we, b.addr, b.wd});
          end
        end else w++;
      end
      @(posedge CLK); #1 mem_ack = 1'b0;
      @(negedge CLK);
    end
    chk({tag, " stall cycles"}, stalls, exp_stalls);
    chk({tag, " bus left"}, bus_q.size(), 32'd0);
    chk({tag, " req dropped"}, mem_req, 1'b0);
    e = sb_q.pop_front();
    chk({tag, " result"}, Result_out, e.res);
    chk({tag, " wr_id"}, Wr_id_out, e.id);
    chk({tag, " fmask/flags"}, {Fmask_out, Flags_out}, {8'hF0, 8'h5A});
  endtask

  task automatic retire;
    @(posedge CLK); #1 Valid_in = 1'b0; Mem_op_in = 2'b00;
  endtask

  initial begin
    RST = 1'b1; Valid_in = 0; Wr_id_in = 0; Fmask_in = 0; Result_in = 0; Flags_in = 0;
    Addr_in = 0; Mem_op_in = 0; Mem_size_in = 0; stall_in = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset bus", {mem_req, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("reset stall", stall_out, 1'b0);
    @(posedge CLK); #1 RST = 1'b0;

    drive(2'b00, 1'b0, 16'h0000, 16'h1234, 5'd5);
    push_exp(16'h1234, 5'd5);
    run_op("alu", 0, 8'h00, 8'h00, 0);
    drive(2'b11, 1'b1, 16'h4000, 16'hCAFE, 5'd9);
    push_exp(16'hCAFE, 5'd9);
    run_op("op11", 0, 8'h00, 8'h00, 0);
    retire();

    drive(2'b01, 1'b0, 16'h8000, 16'h0000, 5'd7);
    push_bus(1'b0, 16'h8000, 8'h00);
    push_exp(16'h00A5, 5'd7);
    run_op("byte rd", 2, 8'hA5, 8'h00, 4);
    retire();

    drive(2'b01, 1'b1, 16'hFFFF, 16'h0000, 5'd3);
    push_bus(1'b0, 16'hFFFF, 8'h00);
    push_bus(1'b0, 16'h0000, 8'h00);
    push_exp(16'h1234, 5'd3);
    run_op("word rd", 0, 8'h34, 8'h12, 3);
    retire();

    drive(2'b10, 1'b1, 16'hC000, 16'hBEEF, 5'd0);
    push_bus(1'b1, 16'hC000, 8'hEF);
    push_bus(1'b1, 16'hC001, 8'hBE);
    push_exp(16'hBEEF, 5'd0);
    run_op("word wr", 1, 8'h00, 8'h00, 5);
    retire();

    stall_in = 1'b1;
    drive(2'b01, 1'b0, 16'h0100, 16'h1234, 5'd11);
    push_bus(1'b0, 16'h0100, 8'h34);
    push_exp(16'h0077, 5'd11);
    run_op("held", 0, 8'h77, 8'h00, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("held stall", {stall_out, mem_req}, 32'd0);
      chk("held result", Result_out, 16'h0077);
      chk("held wr_id", Wr_id_out, 5'd11);
    end
    stall_in = 1'b0; Valid_in = 1'b0;
    @(negedge CLK);
    chk("released result", Result_out, 16'h1234);
    chk("released idle", {stall_out, mem_req}, 32'd0);

    @(posedge CLK); #1 drive(2'b01, 1'b1, 16'h2000, 16'h0000, 5'd4);
    @(negedge CLK);
    chk("rst launch stall", stall_out, 1'b1);
    @(negedge CLK);
    chk("rst lo addr", {mem_req, mem_addr}, {1'b1, 16'h2000});
    mem_ack = 1'b1; mem_rdata = 8'h11;
    @(posedge CLK); #1 mem_ack = 1'b0;
    @(negedge CLK);
    chk("rst hi addr", {mem_req, mem_addr}, {1'b1, 16'h2001});
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0; Valid_in = 1'b0; Result_in = 16'h0BAD;
    @(negedge CLK);
    chk("rst mid req", {mem_req, stall_out}, 32'd0);
    chk("rst no partial", Result_out, 16'h0BAD);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    @(posedge CLK); #1 mem_ack = 1'b0;
    @(negedge CLK);
    chk("stray ack", {mem_req, stall_out, mem_addr}, 32'd0);

    @(posedge CLK); #1 drive(2'b01, 1'b0, 16'h3000, 16'h0000, 5'd6);
    push_bus(1'b0, 16'h3000, 8'h00);
    push_exp(16'h005C, 5'd6);
    run_op("post rst rd", 0, 8'h5C, 8'h00, 2);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
